stream_demux1to2: RTL and testbench

- Registered 1-to-2 stream demultiplexer with valid/ready handshake on the input and on both output lanes.
- Upstream feeds it a word plus a destination select, or the block distributes words alternately between lanes itself.
- It sits in front of the combinational 1:2 demux path and consumes the same din/sel style stream.
- It adds per-lane output holding registers, backpressure and per-lane delivered-word counters.

---
 rtl/stream_demux1to2_pkg.sv | 29 ++
 rtl/stream_demux1to2_lane_reg.sv | 59 +++++
 rtl/stream_demux1to2.sv | 86 ++++++++
 tb/tb_stream_demux1to2.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/stream_demux1to2_pkg.sv
// Shared definitions for the registered 1:2 stream demultiplexer:
// routing-mode encodings, default widths and the target-lane helper.
package stream_demux1to2_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_COUNT_W = 8;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  typedef enum logic {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

  // In round-robin mode the lane comes from the alternation pointer and sel is ignored.
  function automatic lane_e pick_lane(input mode_e mode, input logic sel, input logic rr_ptr);
    lane_e lane;
    if (mode == MODE_RR) begin
      lane = lane_e'(rr_ptr);
    end else begin
      lane = lane_e'(sel);
    end
    return lane;
  endfunction

endpackage

// File: rtl/stream_demux1to2_lane_reg.sv
// One output lane: single-entry holding register with valid flag, load/drain
// control and a wrapping count of words delivered downstream.
module stream_demux1to2_lane_reg
  import stream_demux1to2_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DATA_W-1:0]  din_i,
  input  logic               ready_i,
  output logic [DATA_W-1:0]  data_o,
  output logic               valid_o,
  output logic               can_load_o,
  output logic [COUNT_W-1:0] cnt_o
);

  logic [DATA_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d;
  logic               drain;

  assign drain      = valid_q && ready_i;
  // A word being drained this cycle frees the slot for a same-cycle reload.
  assign can_load_o = !valid_q || ready_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (drain) begin
      valid_d = 1'b0;
      cnt_d   = cnt_q + COUNT_W'(1);
    end
    if (load_i) begin
      data_d  = din_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/stream_demux1to2.sv
// Registered 1:2 stream demultiplexer: routes each accepted input word to lane 0
// or lane 1, either by sel or by strict alternation, with per-lane backpressure.
module stream_demux1to2
  import stream_demux1to2_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [DATA_W-1:0]  din,
  input  logic               sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DATA_W-1:0]  y0,
  output logic               y0_valid,
  input  logic               y0_ready,
  output logic [DATA_W-1:0]  y1,
  output logic               y1_valid,
  input  logic               y1_ready,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both 1;
  // valid never depends on ready, and a held word stays stable until it transfers.
  lane_e tgt;
  logic  rr_ptr_q, rr_ptr_d;
  logic  can_load0, can_load1;
  logic  accept;
  logic  load0, load1;

  assign tgt      = pick_lane(mode_e'(mode), sel, rr_ptr_q);
  assign in_ready = (tgt == LANE1) ? can_load1 : can_load0;
  assign accept   = in_valid && in_ready;
  assign load0    = accept && (tgt == LANE0);
  assign load1    = accept && (tgt == LANE1);

  // The pointer only advances on round-robin accepts, so it is preserved across mode=0 spans.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && (mode_e'(mode) == MODE_RR)) begin
      rr_ptr_d = ~rr_ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

  stream_demux1to2_lane_reg #(
    .DATA_W  (DATA_W),
    .COUNT_W (COUNT_W)
  ) u_lane0 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load0),
    .din_i      (din),
    .ready_i    (y0_ready),
    .data_o     (y0),
    .valid_o    (y0_valid),
    .can_load_o (can_load0),
    .cnt_o      (cnt0)
  );

  stream_demux1to2_lane_reg #(
    .DATA_W  (DATA_W),
    .COUNT_W (COUNT_W)
  ) u_lane1 (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load1),
    .din_i      (din),
    .ready_i    (y1_ready),
    .data_o     (y1),
    .valid_o    (y1_valid),
    .can_load_o (can_load1),
    .cnt_o      (cnt1)
  );

endmodule

// File: tb/tb_stream_demux1to2.sv
// Directed bench for stream_demux1to2: routing, backpressure, reload, round-robin,
// counter wrap (narrow-counter instance) and reset behaviour.
module tb_stream_demux1to2;

  logic       clk = 1'b0;
  logic       rst;
  logic       mode;
  logic [7:0] din;
  logic       sel;
  logic       in_valid;
  logic       y0_ready;
  logic       y1_ready;

  logic       in_ready, y0_valid, y1_valid;
  logic [7:0] y0, y1, cnt0, cnt1;

  logic       w_in_ready, w_y0_valid, w_y1_valid;
  logic [7:0] w_y0, w_y1;
  logic [1:0] w_cnt0, w_cnt1;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  stream_demux1to2 #(.DATA_W(8), .COUNT_W(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(in_ready), .y0(y0), .y0_valid(y0_valid), .y0_ready(y0_ready),
    .y1(y1), .y1_valid(y1_valid), .y1_ready(y1_ready), .cnt0(cnt0), .cnt1(cnt1)
  );

  stream_demux1to2 #(.DATA_W(8), .COUNT_W(2)) dut_w (
    .clk(clk), .rst(rst), .mode(mode), .din(din), .sel(sel), .in_valid(in_valid),
    .in_ready(w_in_ready), .y0(w_y0), .y0_valid(w_y0_valid), .y0_ready(y0_ready),
    .y1(w_y1), .y1_valid(w_y1_valid), .y1_ready(y1_ready), .cnt0(w_cnt0), .cnt1(w_cnt1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; mode = 1'b0; sel = 1'b0; din = 8'hFF; in_valid = 1'b1;
    y0_ready = 1'b0; y1_ready = 1'b0;
    step();
    step();
    total_cnt++; if (y0 !== 8'h00) $display("FAIL reset_y0: got %h want 00", y0); else pass_cnt++;
    total_cnt++; if (y1 !== 8'h00) $display("FAIL reset_y1: got %h want 00", y1); else pass_cnt++;
    total_cnt++; if (y0_valid !== 1'b0) $display("FAIL reset_y0_valid: got %b want 0", y0_valid); else pass_cnt++;
    total_cnt++; if (y1_valid !== 1'b0) $display("FAIL reset_y1_valid: got %b want 0", y1_valid); else pass_cnt++;
    total_cnt++; if (cnt0 !== 8'd0) $display("FAIL reset_cnt0: got %0d want 0", cnt0); else pass_cnt++;
    total_cnt++; if (cnt1 !== 8'd0) $display("FAIL reset_cnt1: got %0d want 0", cnt1); else pass_cnt++;
    rst = 1'b0; in_valid = 1'b0;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_sel_route();
    do_reset();
    mode = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
    din = 8'hA5; sel = 1'b0; in_valid = 1'b1;
    step();
    total_cnt++; if (y0 !== 8'hA5) $display("FAIL route_y0: got %h want a5", y0); else pass_cnt++;
    total_cnt++; if (y0_valid !== 1'b1) $display("FAIL route_y0_valid: got %b want 1", y0_valid); else pass_cnt++;
    total_cnt++; if (y1_valid !== 1'b0) $display("FAIL route_y1_idle: got %b want 0", y1_valid); else pass_cnt++;
    din = 8'h3C; sel = 1'b1;
    step();
    total_cnt++; if (y1 !== 8'h3C) $display("FAIL route_y1: got %h want 3c", y1); else pass_cnt++;
    total_cnt++; if (y1_valid !== 1'b1) $display("FAIL route_y1_valid: got %b want 1", y1_valid); else pass_cnt++;
    total_cnt++; if (y0_valid !== 1'b0) $display("FAIL route_y0_drained: got %b want 0", y0_valid); else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++; if (cnt0 !== 8'd1) $display("FAIL route_cnt0: got %0d want 1", cnt0); else pass_cnt++;
    total_cnt++; if (cnt1 !== 8'd1) $display("FAIL route_cnt1: got %0d want 1", cnt1); else pass_cnt++;
    total_cnt++; if (y1 !== 8'h3C) $display("FAIL route_y1_keeps: got %h want 3c", y1); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    do_reset();
    mode = 1'b0; y0_ready = 1'b0; y1_ready = 1'b1;
    din = 8'h11; sel = 1'b0; in_valid = 1'b1;
    step();
    total_cnt++; if (y0_valid !== 1'b1) $display("FAIL bp_y0_valid: got %b want 1", y0_valid); else pass_cnt++;
    din = 8'h22;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_stall: got %b want 0", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (y0 !== 8'h11) $display("FAIL bp_y0_hold: got %h want 11", y0); else pass_cnt++;
    din = 8'h33; sel = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_other: got %b want 1", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (y1 !== 8'h33) $display("FAIL bp_y1: got %h want 33", y1); else pass_cnt++;
    total_cnt++; if (y0 !== 8'h11) $display("FAIL bp_y0_hold2: got %h want 11", y0); else pass_cnt++;
    din = 8'h22; sel = 1'b0; y0_ready = 1'b1;
    step();
    total_cnt++; if (y0 !== 8'h22) $display("FAIL bp_y0_reload: got %h want 22", y0); else pass_cnt++;
    total_cnt++; if (cnt0 !== 8'd1) $display("FAIL bp_cnt0_first: got %0d want 1", cnt0); else pass_cnt++;
    total_cnt++; if (cnt1 !== 8'd1) $display("FAIL bp_cnt1: got %0d want 1", cnt1); else pass_cnt++;
    in_valid = 1'b0;
    step();
    total_cnt++; if (y0_valid !== 1'b0) $display("FAIL bp_y0_empty: got %b want 0", y0_valid); else pass_cnt++;
    total_cnt++; if (cnt0 !== 8'd2) $display("FAIL bp_cnt0: got %0d want 2", cnt0); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] w;
    do_reset();
    mode = 1'b0; sel = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = 8'(i + 1);
      din = w; in_valid = 1'b1;
      #1;
      total_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready); else pass_cnt++;
      step();
      total_cnt++; if (y0 !== w || y0_valid !== 1'b1) $display("FAIL b2b_y0[%0d]: got %h/%b want %h/1", i, y0, y0_valid, w); else pass_cnt++;
    end
    in_valid = 1'b0;
    step();
    total_cnt++; if (cnt0 !== 8'd4) $display("FAIL b2b_cnt0: got %0d want 4", cnt0); else pass_cnt++;
    total_cnt++; if (y0_valid !== 1'b0) $display("FAIL b2b_y0_empty: got %b want 0", y0_valid); else pass_cnt++;
  endtask

  task automatic test_round_robin();
    logic [7:0] w;
    do_reset();
    mode = 1'b1; sel = 1'b0; y0_ready = 1'b1; y1_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      w = 8'h10 + 8'(i);
      din = w; in_valid = 1'b1;
      step();
      if (i % 2 == 0) begin
        total_cnt++; if (y0 !== w || y0_valid !== 1'b1) $display("FAIL rr_y0[%0d]: got %h/%b want %h/1", i, y0, y0_valid, w); else pass_cnt++;
      end else begin
        total_cnt++; if (y1 !== w || y1_valid !== 1'b1) $display("FAIL rr_y1[%0d]: got %h/%b want %h/1", i, y1, y1_valid, w); else pass_cnt++;
      end
    end
    in_valid = 1'b0;
    step();
    total_cnt++; if (cnt0 !== 8'd3 || cnt1 !== 8'd3) $display("FAIL rr_counts: got %0d/%0d want 3/3", cnt0, cnt1); else pass_cnt++;

    do_reset();
    din = 8'h10; in_valid = 1'b1;
    step();
    din = 8'h11;
    step();
    y1_ready = 1'b0;
    din = 8'h12;
    step();
    total_cnt++; if (y0 !== 8'h12) $display("FAIL rr_stall_y0: got %h want 12", y0); else pass_cnt++;
    din = 8'h13;
    #1;
    total_cnt++; if (in_ready !== 1'b0) $display("FAIL rr_stall_in_ready: got %b want 0", in_ready); else pass_cnt++;
    step();
    total_cnt++; if (y1 !== 8'h11 || y1_valid !== 1'b1) $display("FAIL rr_stall_y1_hold: got %h/%b want 11/1", y1, y1_valid); else pass_cnt++;
    y1_ready = 1'b1;
    step();
    total_cnt++; if (y1 !== 8'h13) $display("FAIL rr_resume_y1: got %h want 13", y1); else pass_cnt++;
    total_cnt++; if (cnt0 !== 8'd2 || cnt1 !== 8'd1) $display("FAIL rr_resume_counts: got %0d/%0d want 2/1", cnt0, cnt1); else pass_cnt++;
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    mode = 1'b0; sel = 1'b1; y0_ready = 1'b1; y1_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = 8'h40 + 8'(i); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    step();
    total_cnt++; if (cnt1 !== 8'd5) $display("FAIL wrap_wide_cnt1: got %0d want 5", cnt1); else pass_cnt++;
    total_cnt++; if (w_cnt1 !== 2'd1) $display("FAIL wrap_narrow_cnt1: got %0d want 1", w_cnt1); else pass_cnt++;
    y0_ready = 1'b0; sel = 1'b0; din = 8'h77; in_valid = 1'b1;
    step();
    total_cnt++; if (y0_valid !== 1'b1) $display("FAIL mid_pending: got %b want 1", y0_valid); else pass_cnt++;
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    total_cnt++; if (y0_valid !== 1'b0 || y0 !== 8'h00) $display("FAIL mid_reset_y0: got %h/%b want 00/0", y0, y0_valid); else pass_cnt++;
    total_cnt++; if (cnt1 !== 8'd0 || w_cnt1 !== 2'd0) $display("FAIL mid_reset_cnt1: got %0d/%0d want 0/0", cnt1, w_cnt1); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_sel_route();
    test_backpressure();
    test_back_to_back();
    test_round_robin();
    test_wrap_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
